// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Holds the state encoding, default widths and the timer width helper.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_TIMEOUT   = 15;

  // Bits needed to hold 0..t.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Sequencer bus: memory read port, datapath handshake, PC strobes, status.
// master = sequencer side, slave = memory/datapath/PC side.
interface fetch_sequencer_if
  import fetch_seq_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE
);

  logic                 mem_rd;
  logic                 mem_ready;
  logic [DATA_SIZE-1:0] mem_data;
  logic [DATA_SIZE-1:0] ir;
  logic                 exec_start;
  logic                 exec_done;
  logic                 branch_taken;
  logic [DATA_SIZE-1:0] branch_target;
  logic                 halt_req;
  logic                 load_pc;
  logic                 inc_pc;
  logic [DATA_SIZE-1:0] pc_data;
  logic                 halted;
  logic                 fetch_err;

  modport master (
    output mem_rd,
    input  mem_ready,
    input  mem_data,
    output ir,
    output exec_start,
    input  exec_done,
    input  branch_taken,
    input  branch_target,
    input  halt_req,
    output load_pc,
    output inc_pc,
    output pc_data,
    output halted,
    output fetch_err
  );

  modport slave (
    input  mem_rd,
    output mem_ready,
    output mem_data,
    input  ir,
    input  exec_start,
    output exec_done,
    output branch_taken,
    output branch_target,
    output halt_req,
    input  load_pc,
    input  inc_pc,
    input  pc_data,
    input  halted,
    input  fetch_err
  );

endinterface

// File: rtl/fetch_sequencer_wait_timer.sv
// Fetch wait counter: counts stalled cycles, flags the last allowed one.
// Ports: clk, rst (async low), clear, enable -> expired.
module wait_timer #(
  parameter int LIMIT = 15,
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  // High on the stall cycle whose increment would reach LIMIT.
  assign expired = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue/execute/halt sequencer driving the program counter strobes.
// Ports: clk, rst (async low), bus (fetch_sequencer_if.master).
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  localparam int CW = cnt_width(TIMEOUT);

  state_t               state;
  logic [DATA_SIZE-1:0] ir_q;
  logic                 err_q;
  logic                 expired;

  logic in_fetch;
  logic in_issue;
  logic in_exec;
  logic in_halt;
  logic take;
  logic redirect;

  // Gated by rst so every strobe reads 0 while reset is held.
  assign in_fetch = rst && (state == S_FETCH);
  assign in_issue = rst && (state == S_ISSUE);
  assign in_exec  = rst && (state == S_EXEC);
  assign in_halt  = rst && (state == S_HALT);

  assign take     = in_fetch && bus.mem_ready;
  assign redirect = in_exec && bus.exec_done
                 && bus.branch_taken;

  wait_timer #(
    .LIMIT (TIMEOUT),
    .WIDTH (CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_fetch || bus.mem_ready),
    .enable  (in_fetch && !bus.mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      ir_q  <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir_q  <= bus.mem_data;
            state <= S_ISSUE;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= S_HALT;
          end
        end
        S_ISSUE: state <= S_EXEC;
        S_EXEC: begin
          if (bus.exec_done)
            state <= bus.halt_req ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          // A timeout halt is sticky until reset.
          if (!bus.halt_req && !err_q)
            state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.mem_rd     = in_fetch;
  assign bus.inc_pc     = take;
  assign bus.exec_start = in_issue;
  assign bus.load_pc    = redirect;
  assign bus.pc_data    = redirect ? bus.branch_target : '0;
  assign bus.halted     = in_halt;
  assign bus.ir         = ir_q;
  assign bus.fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer.
// Table of per-cycle stimulus/expectations plus reset/timeout sequences.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  typedef struct {
    logic       mr;
    logic [7:0] md;
    logic       ed;
    logic       bt;
    logic [7:0] tgt;
    logic       hr;
    logic       e_rd;
    logic       e_inc;
    logic       e_es;
    logic       e_ld;
    logic [7:0] e_pcd;
    logic       e_h;
    logic       e_fe;
    logic [7:0] e_ir;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_sequencer_if #(.DATA_SIZE(8)) bus ();

  fetch_sequencer #(
    .DATA_SIZE (8),
    .TIMEOUT   (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.mem_ready     = v.mr;
    bus.mem_data      = v.md;
    bus.exec_done     = v.ed;
    bus.branch_taken  = v.bt;
    bus.branch_target = v.tgt;
    bus.halt_req      = v.hr;
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".mem_rd"},     8'(bus.mem_rd),     8'(v.e_rd));
    chk({tag, ".inc_pc"},     8'(bus.inc_pc),     8'(v.e_inc));
    chk({tag, ".exec_start"}, 8'(bus.exec_start), 8'(v.e_es));
    chk({tag, ".load_pc"},    8'(bus.load_pc),    8'(v.e_ld));
    chk({tag, ".pc_data"},    bus.pc_data,        v.e_pcd);
    chk({tag, ".halted"},     8'(bus.halted),     8'(v.e_h));
    chk({tag, ".fetch_err"},  8'(bus.fetch_err),  8'(v.e_fe));
    chk({tag, ".ir"},         bus.ir,             v.e_ir);
  endtask

  // Asserts reset now with hostile inputs, checks, releases off-edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    bus.mem_ready     = 1'b1;
    bus.mem_data      = 8'hEE;
    bus.exec_done     = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'hAB;
    bus.halt_req      = 1'b1;
    #1;
    chk({tag, ".rst_mem_rd"},     8'(bus.mem_rd),     8'h0);
    chk({tag, ".rst_inc_pc"},     8'(bus.inc_pc),     8'h0);
    chk({tag, ".rst_exec_start"}, 8'(bus.exec_start), 8'h0);
    chk({tag, ".rst_load_pc"},    8'(bus.load_pc),    8'h0);
    chk({tag, ".rst_pc_data"},    bus.pc_data,        8'h0);
    chk({tag, ".rst_halted"},     8'(bus.halted),     8'h0);
    chk({tag, ".rst_fetch_err"},  8'(bus.fetch_err),  8'h0);
    chk({tag, ".rst_ir"},         bus.ir,             8'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.mem_ready     = 1'b0;
    bus.mem_data      = 8'h00;
    bus.exec_done     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    bus.halt_req      = 1'b0;
  endtask

  vec_t tbl[14];
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive('{0,8'h00,0,0,8'h00,0, 0,0,0,0,8'h00,0,0,8'h00});

    //          mr md    ed bt tgt   hr  rd in es ld pcd   h fe ir
    tbl[0]  = '{1,8'h3A,0,0,8'h00,0, 1,1,0,0,8'h00,0,0,8'h00};
    tbl[1]  = '{0,8'h00,0,0,8'h00,0, 0,0,1,0,8'h00,0,0,8'h3A};
    tbl[2]  = '{0,8'h00,0,0,8'h00,0, 0,0,0,0,8'h00,0,0,8'h3A};
    tbl[3]  = '{0,8'h00,1,1,8'h80,0, 0,0,0,1,8'h80,0,0,8'h3A};
    tbl[4]  = '{0,8'h00,0,0,8'h00,0, 1,0,0,0,8'h00,0,0,8'h3A};
    tbl[5]  = '{1,8'hC4,0,0,8'h00,0, 1,1,0,0,8'h00,0,0,8'h3A};
    tbl[6]  = '{1,8'h11,1,1,8'h77,0, 0,0,1,0,8'h00,0,0,8'hC4};
    tbl[7]  = '{0,8'h00,1,0,8'h99,0, 0,0,0,0,8'h00,0,0,8'hC4};
    tbl[8]  = '{1,8'h22,0,0,8'h00,0, 1,1,0,0,8'h00,0,0,8'hC4};
    tbl[9]  = '{0,8'h00,0,0,8'h00,1, 0,0,1,0,8'h00,0,0,8'h22};
    tbl[10] = '{1,8'hFF,1,1,8'h40,1, 0,0,0,1,8'h40,0,0,8'h22};
    tbl[11] = '{1,8'hFF,0,0,8'h00,1, 0,0,0,0,8'h00,1,0,8'h22};
    tbl[12] = '{0,8'h00,0,0,8'h00,0, 0,0,0,0,8'h00,1,0,8'h22};
    tbl[13] = '{0,8'h00,0,0,8'h00,0, 1,0,0,0,8'h00,0,0,8'h22};

    @(negedge clk);
    do_reset("init");
    for (int i = 0; i < 14; i++)
      step($sformatf("tbl%0d", i), tbl[i]);

    // Ready arriving on the last allowed stall cycle still captures.
    @(negedge clk);
    do_reset("edge");
    v = '{0,8'h00,0,0,8'h00,0, 1,0,0,0,8'h00,0,0,8'h00};
    for (int i = 0; i < 14; i++)
      step($sformatf("edge_wait%0d", i), v);
    step("edge_take",
         '{1,8'h5A,0,0,8'h00,0, 1,1,0,0,8'h00,0,0,8'h00});
    step("edge_issue",
         '{0,8'h00,0,0,8'h00,0, 0,0,1,0,8'h00,0,0,8'h5A});

    // Fifteen stalled cycles: error, sticky halt until reset.
    @(negedge clk);
    do_reset("tmo");
    for (int i = 0; i < 15; i++)
      step($sformatf("tmo_wait%0d", i), v);
    for (int i = 0; i < 3; i++)
      step($sformatf("tmo_halt%0d", i),
           '{1,8'h66,1,0,8'h00,0, 0,0,0,0,8'h00,1,1,8'h00});
    @(negedge clk);
    do_reset("tmo_clr");
    step("tmo_after",
         '{0,8'h00,0,0,8'h00,0, 1,0,0,0,8'h00,0,0,8'h00});

    // Reset landing mid-execution abandons the instruction.
    @(negedge clk);
    do_reset("mid");
    step("mid_fetch",
         '{1,8'h55,0,0,8'h00,0, 1,1,0,0,8'h00,0,0,8'h00});
    step("mid_issue",
         '{0,8'h00,0,0,8'h00,0, 0,0,1,0,8'h00,0,0,8'h55});
    step("mid_exec",
         '{0,8'h00,0,0,8'h00,0, 0,0,0,0,8'h00,0,0,8'h55});
    #2;
    do_reset("mid_rst");
    step("mid_after",
         '{0,8'h00,0,0,8'h00,0, 1,0,0,0,8'h00,0,0,8'h00});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
